// File: rtl/imem_loader.sv
// Streams a little-endian byte image into instruction memory, zero-pads the tail
// and holds the CPU in reset until the image is complete.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    input  logic          end_program,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_reset,
    output logic          load_done,
    output logic [AW:0]   word_count,
    output logic          error
);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, PAD, RUN, ERROR} state_t;

    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   wc_q, wc_d;
    logic [31:0]   word_q, word_d;
    logic          last_q, last_d;
    logic [AW:0]   wc_inc;

    assign wc_inc = wc_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
            addr_q     <= '0;
            wc_q       <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            addr_q     <= addr_d;
            wc_q       <= wc_d;
            word_q     <= word_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        addr_d     = addr_q;
        wc_d       = wc_q;
        word_d     = word_q;
        last_d     = last_q;
        imem_we    = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;

        case (state_q)
            IDLE, ERROR: begin
                if (start) begin
                    state_d    = LOAD;
                    byte_idx_d = '0;
                    addr_d     = '0;
                    wc_d       = '0;
                    word_d     = '0;
                    last_d     = 1'b0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    // word_q is cleared after every write, so a short final word
                    // comes out zero-filled without extra masking.
                    word_d     = word_q | (32'(in_data) << {byte_idx_q, 3'b000});
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3 || in_last) begin
                        state_d    = WRITE;
                        byte_idx_d = '0;
                        last_d     = in_last;
                    end
                end
            end
            WRITE: begin
                imem_we    = 1'b1;
                imem_addr  = addr_q;
                imem_wdata = word_q;
                wc_d       = wc_inc;
                addr_d     = addr_q + 1'b1;
                word_d     = '0;
                if (last_q)
                    state_d = (wc_inc == DEPTH_W) ? RUN : PAD;
                else
                    state_d = (wc_inc == DEPTH_W) ? ERROR : LOAD;
            end
            PAD: begin
                // addr_q starts at word_count, left there by the final WRITE
                imem_we   = 1'b1;
                imem_addr = addr_q;
                addr_d    = addr_q + 1'b1;
                if (addr_q == LAST_ADDR)
                    state_d = RUN;
            end
            RUN: begin
                if (end_program)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == LOAD);
    assign cpu_reset  = (state_q != RUN);
    assign load_done  = (state_q == RUN);
    assign error      = (state_q == ERROR);
    assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a DEPTH=64 instance for normal loads and a
// DEPTH=4 instance for overflow and exact-fit boundaries.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start, in_valid, in_last, end_program;
    logic [7:0]  in_data;
    logic        in_ready, imem_we, cpu_reset, load_done, error;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  word_count;

    logic        b_start, b_in_valid, b_in_last, b_end_program;
    logic [7:0]  b_in_data;
    logic        b_in_ready, b_imem_we, b_cpu_reset, b_load_done, b_error;
    logic [1:0]  b_imem_addr;
    logic [31:0] b_imem_wdata;
    logic [2:0]  b_word_count;

    imem_loader #(.DEPTH(64), .AW(6)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .end_program(end_program), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .load_done(load_done),
        .word_count(word_count), .error(error)
    );

    imem_loader #(.DEPTH(4), .AW(2)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .in_valid(b_in_valid),
        .in_data(b_in_data), .in_last(b_in_last), .in_ready(b_in_ready),
        .end_program(b_end_program), .imem_we(b_imem_we), .imem_addr(b_imem_addr),
        .imem_wdata(b_imem_wdata), .cpu_reset(b_cpu_reset), .load_done(b_load_done),
        .word_count(b_word_count), .error(b_error)
    );

    int checks = 0;
    int failures = 0;

    // Write capture: memories are poisoned on each start so padding is visible.
    logic [31:0] mem [64];
    logic [31:0] memb [4];
    int nwr = 0, nwr_b = 0, bus_bad = 0;

    always @(negedge clk) begin
        if (start) begin
            for (int i = 0; i < 64; i++) mem[i] = 32'hDEADBEEF;
            nwr = 0;
        end
        if (b_start) begin
            for (int i = 0; i < 4; i++) memb[i] = 32'hDEADBEEF;
            nwr_b = 0;
        end
        if (imem_we) begin
            mem[imem_addr] = imem_wdata;
            nwr++;
            if (in_ready) bus_bad++;
        end else if (imem_addr != 0 || imem_wdata != 0) bus_bad++;
        if (b_imem_we) begin
            memb[b_imem_addr] = b_imem_wdata;
            nwr_b++;
            if (b_in_ready) bus_bad++;
        end else if (b_imem_addr != 0 || b_imem_wdata != 0) bus_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) b_start = 1'b1; else start = 1'b1;
        tick();
        b_start = 1'b0;
        start = 1'b0;
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit last, input int gap);
        int n;
        repeat (gap) tick();
        if (sel) begin b_in_valid = 1'b1; b_in_data = d; b_in_last = last; end
        else     begin in_valid = 1'b1;   in_data = d;   in_last = last;   end
        n = 0;
        while (!(sel ? b_in_ready : in_ready) && n < 50) begin tick(); n++; end
        if (n >= 50) begin
            failures++;
            $display("FAIL send_timeout in_ready observed=0 expected=1");
        end
        tick();
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        b_in_valid = 1'b0; b_in_last = 1'b0; b_in_data = '0;
    endtask

    task automatic wait_done(input bit sel);
        for (int n = 0; n < 300; n++) begin
            if (sel ? b_load_done : load_done) break;
            tick();
        end
    endtask

    logic [7:0] img1 [8] = '{8'h63, 8'h04, 8'h00, 8'h00, 8'h13, 8'h03, 8'h30, 8'h00};
    logic [7:0] img2 [5] = '{8'h13, 8'h03, 8'h30, 8'h00, 8'hAA};

    initial begin
        reset = 1'b0;
        start = 0; in_valid = 0; in_last = 0; in_data = 0; end_program = 0;
        b_start = 0; b_in_valid = 0; b_in_last = 0; b_in_data = 0; b_end_program = 0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_error", error, 0);
        tick();
        reset = 1'b1;
        repeat (4) tick();
        chk("idle_hold_in_ready", in_ready, 0);
        chk("idle_hold_cpu_reset", cpu_reset, 1);

        // two full words, last on byte 8
        pulse_start(0);
        chk("load_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) send(0, img1[i], 0, 0);
        chk("w0_we_latency", imem_we, 1);
        chk("w0_addr", imem_addr, 0);
        chk("w0_data", imem_wdata, 32'h00000463);
        chk("w0_in_ready_low", in_ready, 0);
        for (int i = 4; i < 8; i++) send(0, img1[i], i == 7, 0);
        wait_done(0);
        chk("img1_load_done", load_done, 1);
        chk("img1_cpu_reset", cpu_reset, 0);
        chk("img1_word_count", word_count, 2);
        chk("img1_mem0", mem[0], 32'h00000463);
        chk("img1_mem1", mem[1], 32'h00300313);
        chk("img1_mem2", mem[2], 0);
        chk("img1_mem63", mem[63], 0);
        chk("img1_nwr", nwr, 64);

        end_program = 1'b1;
        tick();
        end_program = 1'b0;
        chk("endprog_load_done", load_done, 0);
        chk("endprog_cpu_reset", cpu_reset, 1);
        chk("endprog_wc_hold", word_count, 2);

        // partial final word
        pulse_start(0);
        for (int i = 0; i < 5; i++) send(0, img2[i], i == 4, 0);
        chk("part_we", imem_we, 1);
        chk("part_addr", imem_addr, 1);
        chk("part_data", imem_wdata, 32'h000000AA);
        wait_done(0);
        chk("part_word_count", word_count, 2);
        chk("part_mem0", mem[0], 32'h00300313);
        chk("part_mem1", mem[1], 32'h000000AA);
        chk("part_mem2", mem[2], 0);
        chk("part_nwr", nwr, 64);
        end_program = 1'b1; tick(); end_program = 1'b0;

        // gapped delivery of img1, with a stall after three bytes
        pulse_start(0);
        for (int i = 0; i < 3; i++) send(0, img1[i], 0, $urandom_range(0, 3));
        repeat (5) tick();
        chk("gap_no_early_write", nwr, 0);
        for (int i = 3; i < 8; i++) send(0, img1[i], i == 7, $urandom_range(0, 3));
        wait_done(0);
        chk("gap_mem0", mem[0], 32'h00000463);
        chk("gap_mem1", mem[1], 32'h00300313);
        chk("gap_mem40", mem[40], 0);
        chk("gap_nwr", nwr, 64);

        // start in RUN does nothing (capture cleared by the pulse)
        pulse_start(0);
        repeat (3) tick();
        chk("run_start_ignored", load_done, 1);
        chk("run_start_no_write", nwr, 0);
        end_program = 1'b1; tick(); end_program = 1'b0;

        // DEPTH=4 overflow
        pulse_start(1);
        for (int i = 0; i < 16; i++) send(1, 8'(i), 0, 0);
        tick();
        chk("ovf_error", b_error, 1);
        chk("ovf_cpu_reset", b_cpu_reset, 1);
        chk("ovf_in_ready", b_in_ready, 0);
        chk("ovf_nwr", nwr_b, 4);
        chk("ovf_mem0", memb[0], 32'h03020100);
        chk("ovf_mem3", memb[3], 32'h0F0E0D0C);
        repeat (3) tick();
        chk("ovf_no_more_write", nwr_b, 4);
        pulse_start(1);
        chk("recover_error_clr", b_error, 0);
        chk("recover_in_ready", b_in_ready, 1);
        for (int i = 0; i < 4; i++) send(1, 8'h11 * 8'(i + 1), i == 3, 0);
        wait_done(1);
        chk("recover_done", b_load_done, 1);
        chk("recover_wc", b_word_count, 1);
        chk("recover_mem0", memb[0], 32'h44332211);
        chk("recover_mem3", memb[3], 0);
        chk("recover_nwr", nwr_b, 4);
        b_end_program = 1'b1; tick(); b_end_program = 1'b0;

        // exact fit: DEPTH words with in_last goes straight to RUN
        pulse_start(1);
        for (int i = 0; i < 16; i++) send(1, 8'(i + 8'h20), i == 15, 0);
        tick();
        chk("fit_done", b_load_done, 1);
        chk("fit_error", b_error, 0);
        chk("fit_wc", b_word_count, 4);
        chk("fit_nwr", nwr_b, 4);
        chk("fit_mem3", memb[3], 32'h2F2E2D2C);

        // asynchronous reset in the middle of a load
        pulse_start(0);
        for (int i = 0; i < 6; i++) send(0, img1[i], 0, 0);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 0);
        chk("arst_cpu_reset", cpu_reset, 1);
        chk("arst_imem_we", imem_we, 0);
        chk("arst_word_count", word_count, 0);
        chk("arst_b_load_done", b_load_done, 0);
        tick();
        reset = 1'b1;
        repeat (10) tick();
        chk("arst_no_write", nwr, 1);
        chk("arst_idle_in_ready", in_ready, 0);
        chk("arst_idle_cpu_reset", cpu_reset, 1);

        chk("bus_idle_zero", bus_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
